// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage and its consumers.
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   NOP_INSTR_DEFAULT : default bubble instruction (addi x0,x0,0)
//   if_id_t           : IF/ID pipeline bundle, reused by decode
//   if_id_bubble()    : builds the bubble value of the IF/ID bundle
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [31:0] nop_instr);
    if_id_t b;
    b.instr    = nop_instr;
    b.pc       = 32'h0000_0000;
    b.pc_plus4 = 32'h0000_0000;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// PC register with synchronous active-low reset, redirect and enable.
//   clk_i        : clock, all updates on rising edge
//   rst_ni       : synchronous active-low reset, loads ResetPc
//   en_i         : advance to pc + 4 (low holds the PC)
//   redirect_i   : load the redirect target, wins over en_i
//   target_i     : word address of redirect target (byte offset dropped)
//   pc_o         : current PC
//   pc_plus4_o   : pc_o + 4, modulo 2^32
module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] ResetPc = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        redirect_i,
  input  logic [29:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_d, pc_q;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  // Redirect is checked first so a stalled front end never drops a branch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {target_i, 2'b00};
    end else if (en_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, IF/ID pipeline register and a
// counter of valid instructions handed to decode.
//   clk, rst_n          : clock and synchronous active-low reset
//   imem_addr/rdata     : external instruction memory, combinational read
//   stall_f / stall_d   : hold PC / hold IF/ID
//   flush_d             : load bubble into IF/ID (wins over stall_d)
//   pc_src_e, pc_target_e : redirect from execute (wins over stall_f)
//   pc_f                : current fetch PC
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register contents
//   fetch_count         : number of valid captures into IF/ID (wraps)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_plus4_f;
  if_id_t      if_id_d, if_id_q;
  logic [31:0] fetch_count_d, fetch_count_q;

  // Byte offset of the target is dropped: the PC is always word aligned.
  logic unused_target_lsb;
  assign unused_target_lsb = ^pc_target_e[1:0];

  fetch_stage_pc_reg #(
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (~stall_f),
    .redirect_i (pc_src_e),
    .target_i   (pc_target_e[31:2]),
    .pc_o       (pc_f),
    .pc_plus4_o (pc_plus4_f)
  );

  assign imem_addr = pc_f;

  always_comb begin
    if_id_d       = if_id_q;
    fetch_count_d = fetch_count_q;
    if (flush_d) begin
      if_id_d = if_id_bubble(NOP_INSTR);
    end else if (!stall_d) begin
      if_id_d.instr    = imem_rdata;
      if_id_d.pc       = pc_f;
      if_id_d.pc_plus4 = pc_plus4_f;
      if_id_d.valid    = 1'b1;
      fetch_count_d    = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_q       <= if_id_bubble(NOP_INSTR);
      fetch_count_q <= 32'h0000_0000;
    end else begin
      if_id_q       <= if_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outputs come only from registers; imem_rdata never reaches them directly.
  assign instr_d     = if_id_q.instr;
  assign pc_d        = if_id_q.pc;
  assign pc_plus4_d  = if_id_q.pc_plus4;
  assign valid_d     = if_id_q.valid;
  assign fetch_count = fetch_count_q;

endmodule
